// File: rtl/aes_encrypt_iter_if.sv
// Handshake and data bundle between an AES-128 encrypt core and its client.
interface aes_encrypt_iter_if;
    logic         kld;
    logic [127:0] key;
    logic         ld;
    logic [127:0] text_in;
    logic [127:0] text_out;
    logic         done;
    logic         busy;

    modport master (output kld, key, ld, text_in, input text_out, done, busy);
    modport slave  (input kld, key, ld, text_in, output text_out, done, busy);
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption, one round per clock, round keys expanded on the fly.
// ld -> done is 11 cycles; ld and kld arriving while busy are dropped (no backpressure).
module aes_encrypt_iter (
    input  logic               clk,
    input  logic               rst,
    aes_encrypt_iter_if.slave  bus
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_nxt;
    logic [127:0] key_r, rk, st, nk, sr, mc;
    logic [3:0]   rcnt;
    logic [7:0]   rcon;
    logic         arm;
    logic         start, last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // SubBytes fused with ShiftRows: output s[r][c] takes input s[r][(c+r) mod 4].
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)&3)+r) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    always_comb begin
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        nk = {w0, w1, w2, w3};
    end

    assign sr    = sub_shift(st);
    assign mc    = mix_cols(sr);
    assign start = (state == IDLE) && bus.ld && !bus.kld;
    assign last  = (state == RUN) && !arm && (rcnt == 4'd10);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_r        <= '0;
            rk           <= '0;
            st           <= '0;
            rcnt         <= '0;
            rcon         <= '0;
            arm          <= 1'b0;
            bus.text_out <= '0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.kld) key_r <= bus.key;
            if (start) begin
                st   <= bus.text_in ^ key_r;
                rk   <= key_r;
                rcon <= 8'h01;
                rcnt <= 4'd1;
                arm  <= 1'b1;
            end else if (state == RUN) begin
                // First RUN cycle is a hold slot so completion lands 11 edges after ld,
                // matching the decrypt core's cadence.
                if (arm) begin
                    arm <= 1'b0;
                end else begin
                    rk   <= nk;
                    rcon <= xtime(rcon);
                    rcnt <= rcnt + 4'd1;
                    if (last) begin
                        bus.text_out <= sr ^ nk;
                        bus.done     <= 1'b1;
                    end else begin
                        st <= mc ^ nk;
                    end
                end
            end
        end
    end
endmodule
